mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 100 ++++++++++
 rtl/mc_decode.sv | 107 ++++++++++
 rtl/mc_ctrl.sv | 148 ++++++++++++++
 tb/tb_mc_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, datapath
// select codes, state codes and the decoded-instruction bundle.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    localparam logic [4:0] RT_BLTZAL = 5'h10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd4;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_LTZ = 3'd1;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_B   = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [1:0] A3_RT = 2'd0;
    localparam logic [1:0] A3_RD = 2'd1;
    localparam logic [1:0] A3_RA = 2'd2;

    // Four write-data sources fit in two bits, so hi and lo share WD_HILO and
    // MDOp (MD_RD_HI / MD_RD_LO) picks which half the GRF receives.
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DMRD = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;
    localparam logic [1:0] MD_RD_HI = 2'd0;
    localparam logic [1:0] MD_RD_LO = 2'd1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MDWAIT = 3'd5
    } state_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] cmp_op;
        logic [2:0] dm_op;
        logic [2:0] npc_op;
        logic [1:0] a3_sel;
        logic [1:0] wd_sel;
        logic       alub_sel;
        logic       ext_op;
        logic [1:0] md_op;
        logic       load;
        logic       store;
        logic       branch;
        logic       jump;
        logic       md;
        logic       mfhilo;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational instruction decoder: datapath select fields plus the
// class flags the sequencer branches on.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_bits;

    assign opcode      = instr_i[31:26];
    assign rt          = instr_i[20:16];
    assign funct       = instr_i[5:0];
    assign unused_bits = ^{instr_i[25:21], instr_i[15:6]};

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec_o = '0;
        case (opcode)
            OP_RTYPE: begin
                dec_o.a3_sel = A3_RD;
                case (funct)
                    FN_ADDU:  dec_o.alu_op = ALU_ADD;
                    FN_SUBU:  dec_o.alu_op = ALU_SUB;
                    FN_SLT:   dec_o.alu_op = ALU_SLT;
                    FN_JR: begin
                        dec_o.jump   = 1'b1;
                        dec_o.npc_op = NPC_JR;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec_o.md    = 1'b1;
                        dec_o.md_op = funct[1:0];
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec_o.mfhilo = 1'b1;
                        dec_o.wd_sel = WD_HILO;
                        dec_o.md_op  = funct[1] ? MD_RD_LO : MD_RD_HI;
                    end
                    default:  dec_o.illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZAL) begin
                    dec_o.branch = 1'b1;
                    dec_o.cmp_op = CMP_LTZ;
                    dec_o.npc_op = NPC_B;
                    dec_o.a3_sel = A3_RA;
                    dec_o.wd_sel = WD_PC4;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_J: begin
                dec_o.jump   = 1'b1;
                dec_o.npc_op = NPC_J;
            end
            OP_JAL: begin
                dec_o.jump   = 1'b1;
                dec_o.npc_op = NPC_J;
                dec_o.a3_sel = A3_RA;
                dec_o.wd_sel = WD_PC4;
            end
            OP_BEQ: begin
                dec_o.branch = 1'b1;
                dec_o.cmp_op = CMP_EQ;
                dec_o.npc_op = NPC_B;
            end
            OP_ORI: begin
                dec_o.alu_op   = ALU_OR;
                dec_o.alub_sel = 1'b1;
            end
            OP_LUI: begin
                dec_o.alu_op   = ALU_LUI;
                dec_o.alub_sel = 1'b1;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                dec_o.load     = 1'b1;
                dec_o.wd_sel   = WD_DMRD;
                dec_o.alub_sel = 1'b1;
                dec_o.ext_op   = 1'b1;
                case (opcode)
                    OP_LH:   dec_o.dm_op = DM_H;
                    OP_LHU:  dec_o.dm_op = DM_HU;
                    OP_LB:   dec_o.dm_op = DM_B;
                    OP_LBU:  dec_o.dm_op = DM_BU;
                    default: dec_o.dm_op = DM_W;
                endcase
            end
            OP_SW, OP_SH, OP_SB: begin
                dec_o.store    = 1'b1;
                dec_o.alub_sel = 1'b1;
                dec_o.ext_op   = 1'b1;
                case (opcode)
                    OP_SH:   dec_o.dm_op = DM_H;
                    OP_SB:   dec_o.dm_op = DM_B;
                    default: dec_o.dm_op = DM_W;
                endcase
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB/MDWAIT sequencer with a
// memory ready handshake and a parametrised mult/div wait counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        cmp,
    input  logic        mem_ready,
    output logic        PCWrEn,
    output logic        IRWrEn,
    output logic        GRFWrEn,
    output logic        DMWrEn,
    output logic        mem_req,
    output logic        md_start,
    output logic        illegal,
    output logic [3:0]  ALUOp,
    output logic [2:0]  CMPOp,
    output logic [2:0]  DMOp,
    output logic [2:0]  NPCOp,
    output logic [1:0]  GRFA3Sel,
    output logic [1:0]  GRFWDSel,
    output logic        ALUBSel,
    output logic        EXTOp,
    output logic [1:0]  MDOp,
    output logic [2:0]  state
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    dec_t       dec;
    logic       link;
    logic       unused_dec;

    mc_decode u_decode (
        .instr_i (Instr),
        .dec_o   (dec)
    );

    assign link       = (dec.a3_sel == A3_RA);
    assign unused_dec = dec.mfhilo;

    assign ALUOp    = dec.alu_op;
    assign CMPOp    = dec.cmp_op;
    assign DMOp     = dec.dm_op;
    assign GRFA3Sel = dec.a3_sel;
    assign GRFWDSel = dec.wd_sel;
    assign ALUBSel  = dec.alub_sel;
    assign EXTOp    = dec.ext_op;
    assign MDOp     = dec.md_op;
    assign state    = state_q;
    // The IR still holds the previous instruction during FETCH, so the PC update
    // there must be a plain pc+4 regardless of what is being decoded.
    assign NPCOp    = (state_q == ST_FETCH) ? NPC_PC4 : dec.npc_op;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        PCWrEn   = 1'b0;
        IRWrEn   = 1'b0;
        GRFWrEn  = 1'b0;
        DMWrEn   = 1'b0;
        mem_req  = 1'b0;
        md_start = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrEn  = 1'b1;
                    PCWrEn  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (dec.illegal) begin
                    illegal = 1'b1;
                end else if (dec.jump) begin
                    PCWrEn  = 1'b1;
                    GRFWrEn = link;
                end else if (dec.branch) begin
                    PCWrEn  = cmp;
                    GRFWrEn = link & cmp;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (dec.load || dec.store) begin
                    state_d = ST_MEM;
                end else if (dec.md) begin
                    md_start = 1'b1;
                    cnt_d    = dec.md_op[1] ? 8'(DIV_CYCLES - 1) : 8'(MULT_CYCLES - 1);
                    state_d  = ST_MDWAIT;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                DMWrEn  = dec.store;
                if (mem_ready) begin
                    state_d = dec.load ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                GRFWrEn = 1'b1;
                state_d = ST_FETCH;
            end
            ST_MDWAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset abandons whatever is in flight; nothing may be written that cycle.
        if (reset) begin
            PCWrEn   = 1'b0;
            IRWrEn   = 1'b0;
            GRFWrEn  = 1'b0;
            DMWrEn   = 1'b0;
            mem_req  = 1'b0;
            md_start = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so both registers update from pre-edge values together.
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios then random instructions,
// each compared cycle by cycle against a per-instruction state/strobe schedule.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int TB_MULT = 5;
    localparam int TB_DIV  = 1;

    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_MD = 5;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_JUMP = 3, K_BRANCH = 4,
                   K_MUL = 5, K_DIV = 6, K_ILL = 7;
    localparam int NOPS = 27;
    localparam int I_ADDU = 0, I_LW = 5, I_SW = 10, I_SB = 12, I_BEQ = 13,
                   I_BLTZAL = 14, I_JAL = 16, I_MULT = 18, I_DIV = 20, I_ILL = 24;

    typedef struct {
        logic [31:0] base;
        logic [31:0] mask;
        int          cls;
        logic        link;
        logic [20:0] fields;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        cmp;
    logic        mem_ready;
    logic        PCWrEn, IRWrEn, GRFWrEn, DMWrEn, mem_req, md_start, illegal;
    logic [3:0]  ALUOp;
    logic [2:0]  CMPOp, DMOp, NPCOp;
    logic [1:0]  GRFA3Sel, GRFWDSel, MDOp;
    logic        ALUBSel, EXTOp;
    logic [2:0]  state;

    int  n_tests = 0;
    int  n_fail  = 0;
    op_t ops[NOPS];

    always #5 clk = ~clk;

    mc_ctrl #(.MULT_CYCLES(TB_MULT), .DIV_CYCLES(TB_DIV)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .cmp(cmp), .mem_ready(mem_ready),
        .PCWrEn(PCWrEn), .IRWrEn(IRWrEn), .GRFWrEn(GRFWrEn), .DMWrEn(DMWrEn),
        .mem_req(mem_req), .md_start(md_start), .illegal(illegal),
        .ALUOp(ALUOp), .CMPOp(CMPOp), .DMOp(DMOp), .NPCOp(NPCOp),
        .GRFA3Sel(GRFA3Sel), .GRFWDSel(GRFWDSel), .ALUBSel(ALUBSel), .EXTOp(EXTOp),
        .MDOp(MDOp), .state(state)
    );

    function automatic op_t mk(input logic [31:0] base, input logic [31:0] mask,
                               input int cls, input logic link,
                               input logic [3:0] alu, input logic [2:0] cmpop,
                               input logic [2:0] dm, input logic [2:0] npc,
                               input logic [1:0] a3, input logic [1:0] wd,
                               input logic alub, input logic ext, input logic [1:0] md);
        op_t o;
        o.base   = base;
        o.mask   = mask;
        o.cls    = cls;
        o.link   = link;
        o.fields = {alu, cmpop, dm, npc, a3, wd, alub, ext, md};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return 32'({PCWrEn, IRWrEn, GRFWrEn, DMWrEn, mem_req, md_start, illegal});
    endfunction

    // Runs one instruction from its FETCH to its last cycle. rnd supplies the
    // operand bits; abort_at >= 0 asserts reset in that cycle of the schedule.
    task automatic run(input int idx, input logic cmpv, input int fst, input int mst,
                       input int abort_at, input logic [31:0] rnd);
        op_t         o;
        logic [31:0] ins;
        int          q[$];
        logic        last;
        logic [6:0]  e;
        string       tag;
        o   = ops[idx];
        ins = o.base | (rnd & o.mask);
        repeat (fst) q.push_back(S_F);
        q.push_back(S_F);
        q.push_back(S_D);
        case (o.cls)
            K_ALU:   begin q.push_back(S_E); q.push_back(S_W); end
            K_LOAD:  begin q.push_back(S_E); repeat (mst + 1) q.push_back(S_M); q.push_back(S_W); end
            K_STORE: begin q.push_back(S_E); repeat (mst + 1) q.push_back(S_M); end
            K_MUL:   begin q.push_back(S_E); repeat (TB_MULT) q.push_back(S_MD); end
            K_DIV:   begin q.push_back(S_E); repeat (TB_DIV) q.push_back(S_MD); end
            default: ;
        endcase
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            Instr = ins;
            cmp   = cmpv;
            last  = (k == q.size() - 1) || (q[k + 1] != q[k]);
            if (q[k] == S_F || q[k] == S_M) mem_ready = last;
            else                            mem_ready = 1'($urandom_range(0, 1));
            tag = $sformatf("op%0d ins=%h cyc%0d", idx, ins, k);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk({tag, " reset-strobes"}, strobes(), 32'd0);
                chk({tag, " reset-state"}, 32'(state), 32'(q[k]));
                @(negedge clk);
                reset     = 1'b0;
                mem_ready = 1'b0;
                #1;
                chk({tag, " post-reset-state"}, 32'(state), 32'(S_F));
                chk({tag, " post-reset-strobes"}, strobes(), 32'b0000100);
                return;
            end
            #1;
            e = '0;
            case (q[k])
                S_F: begin e[2] = 1'b1; e[6] = mem_ready; e[5] = mem_ready; end
                S_D: begin
                    if (o.cls == K_ILL)    e[0] = 1'b1;
                    if (o.cls == K_JUMP)   begin e[6] = 1'b1; e[4] = o.link; end
                    if (o.cls == K_BRANCH) begin e[6] = cmpv; e[4] = o.link & cmpv; end
                end
                S_E: e[1] = (o.cls == K_MUL || o.cls == K_DIV);
                S_M: begin e[2] = 1'b1; e[3] = (o.cls == K_STORE); end
                S_W: e[4] = 1'b1;
                default: ;
            endcase
            chk({tag, " state"}, 32'(state), 32'(q[k]));
            chk({tag, " strobes"}, strobes(), 32'(e));
            if (q[k] == S_F) chk({tag, " npc-fetch"}, 32'(NPCOp), 32'(NPC_PC4));
            if (q[k] == S_D && o.cls != K_ILL)
                chk({tag, " fields"},
                    32'({ALUOp, CMPOp, DMOp, NPCOp, GRFA3Sel, GRFWDSel, ALUBSel, EXTOp, MDOp}),
                    32'(o.fields));
        end
    endtask

    initial begin
        ops[0]  = mk(32'h00000021, 32'h03FFF800, K_ALU,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, 2'd0);
        ops[1]  = mk(32'h00000023, 32'h03FFF800, K_ALU,    0, ALU_SUB, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, 2'd0);
        ops[2]  = mk(32'h0000002A, 32'h03FFF800, K_ALU,    0, ALU_SLT, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, 2'd0);
        ops[3]  = mk(32'h34000000, 32'h03FFFFFF, K_ALU,    0, ALU_OR,  CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  1, 0, 2'd0);
        ops[4]  = mk(32'h3C000000, 32'h03FFFFFF, K_ALU,    0, ALU_LUI, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  1, 0, 2'd0);
        ops[5]  = mk(32'h8C000000, 32'h03FFFFFF, K_LOAD,   0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_DMRD, 1, 1, 2'd0);
        ops[6]  = mk(32'h84000000, 32'h03FFFFFF, K_LOAD,   0, ALU_ADD, CMP_EQ,  DM_H,  NPC_PC4, A3_RT, WD_DMRD, 1, 1, 2'd0);
        ops[7]  = mk(32'h94000000, 32'h03FFFFFF, K_LOAD,   0, ALU_ADD, CMP_EQ,  DM_HU, NPC_PC4, A3_RT, WD_DMRD, 1, 1, 2'd0);
        ops[8]  = mk(32'h80000000, 32'h03FFFFFF, K_LOAD,   0, ALU_ADD, CMP_EQ,  DM_B,  NPC_PC4, A3_RT, WD_DMRD, 1, 1, 2'd0);
        ops[9]  = mk(32'h90000000, 32'h03FFFFFF, K_LOAD,   0, ALU_ADD, CMP_EQ,  DM_BU, NPC_PC4, A3_RT, WD_DMRD, 1, 1, 2'd0);
        ops[10] = mk(32'hAC000000, 32'h03FFFFFF, K_STORE,  0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  1, 1, 2'd0);
        ops[11] = mk(32'hA4000000, 32'h03FFFFFF, K_STORE,  0, ALU_ADD, CMP_EQ,  DM_H,  NPC_PC4, A3_RT, WD_ALU,  1, 1, 2'd0);
        ops[12] = mk(32'hA0000000, 32'h03FFFFFF, K_STORE,  0, ALU_ADD, CMP_EQ,  DM_B,  NPC_PC4, A3_RT, WD_ALU,  1, 1, 2'd0);
        ops[13] = mk(32'h10000000, 32'h03FFFFFF, K_BRANCH, 0, ALU_ADD, CMP_EQ,  DM_W,  NPC_B,   A3_RT, WD_ALU,  0, 0, 2'd0);
        ops[14] = mk(32'h04100000, 32'h03E0FFFF, K_BRANCH, 1, ALU_ADD, CMP_LTZ, DM_W,  NPC_B,   A3_RA, WD_PC4,  0, 0, 2'd0);
        ops[15] = mk(32'h08000000, 32'h03FFFFFF, K_JUMP,   0, ALU_ADD, CMP_EQ,  DM_W,  NPC_J,   A3_RT, WD_ALU,  0, 0, 2'd0);
        ops[16] = mk(32'h0C000000, 32'h03FFFFFF, K_JUMP,   1, ALU_ADD, CMP_EQ,  DM_W,  NPC_J,   A3_RA, WD_PC4,  0, 0, 2'd0);
        ops[17] = mk(32'h00000008, 32'h03E00000, K_JUMP,   0, ALU_ADD, CMP_EQ,  DM_W,  NPC_JR,  A3_RD, WD_ALU,  0, 0, 2'd0);
        ops[18] = mk(32'h00000018, 32'h03FF0000, K_MUL,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, MD_MULT);
        ops[19] = mk(32'h00000019, 32'h03FF0000, K_MUL,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, MD_MULTU);
        ops[20] = mk(32'h0000001A, 32'h03FF0000, K_DIV,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, MD_DIV);
        ops[21] = mk(32'h0000001B, 32'h03FF0000, K_DIV,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_ALU,  0, 0, MD_DIVU);
        ops[22] = mk(32'h00000010, 32'h0000F800, K_ALU,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_HILO, 0, 0, MD_RD_HI);
        ops[23] = mk(32'h00000012, 32'h0000F800, K_ALU,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RD, WD_HILO, 0, 0, MD_RD_LO);
        ops[24] = mk(32'hFC000000, 32'h03FFFFFF, K_ILL,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  0, 0, 2'd0);
        ops[25] = mk(32'h0000003F, 32'h03FFF800, K_ILL,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  0, 0, 2'd0);
        ops[26] = mk(32'h04000000, 32'h03E0FFFF, K_ILL,    0, ALU_ADD, CMP_EQ,  DM_W,  NPC_PC4, A3_RT, WD_ALU,  0, 0, 2'd0);

        reset     = 1'b1;
        Instr     = 32'h00221821;
        cmp       = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset state", 32'(state), 32'(S_F));
        chk("reset strobes", strobes(), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("first mem_req", strobes(), 32'b0000100);

        run(I_ADDU,   1'b0, 0, 0, -1, 32'h00221821);
        run(I_LW,     1'b0, 0, 2, -1, 32'h8C020004);
        run(I_SB,     1'b0, 0, 0, -1, 32'hA0010000);
        run(I_BEQ,    1'b1, 0, 0, -1, 32'h10000003);
        run(I_BLTZAL, 1'b0, 0, 0, -1, 32'h04100002);
        run(I_BLTZAL, 1'b1, 1, 0, -1, 32'h04100002);
        run(I_JAL,    1'b0, 2, 0, -1, 32'h0C000010);
        run(I_MULT,   1'b0, 0, 0, -1, 32'h00220018);
        run(I_DIV,    1'b0, 0, 0, -1, 32'h0022001A);
        run(I_MULT,   1'b0, 0, 0,  5, 32'h00220018);
        run(I_SW,     1'b0, 0, 3,  4, 32'hAC010008);
        run(I_ILL,    1'b0, 0, 0, -1, 32'hFC000000);

        for (int i = 0; i < 150; i++) begin
            run($urandom_range(0, NOPS - 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), -1, $urandom);
        end

        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("final state", 32'(state), 32'(S_F));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
